// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first, acc = acc*10 + digit.
// Define BCD_CHECK_EN to flag captured digits above 9 (error=1, binary=0).
module bcd_to_bin #(
  parameter int unsigned NUM_SEGMENTS = 8,
  parameter int unsigned BITS         = 32
) (
  input  logic                         clk,
  input  logic                         CPU_RESETN,
  input  logic                         start,
  input  logic [NUM_SEGMENTS-1:0][3:0] encoded,
  output logic                         busy,
  output logic                         done,
  output logic [BITS-1:0]              binary,
  output logic                         error
);

  localparam int unsigned IdxW = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;

  typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

  state_e                         state_q;
  logic [NUM_SEGMENTS-1:0][3:0]   digit_buf_q;
  logic [BITS-1:0]                acc_q;
  logic [IdxW-1:0]                idx_q;
  logic [3:0]                     cur_digit;
  logic [BITS-1:0]                acc_next;
  logic                           invalid;

  // idx counts up from 0, so the MSD is consumed first.
  always_comb begin
    cur_digit = digit_buf_q[IdxW'(NUM_SEGMENTS - 1) - idx_q];
    acc_next  = (acc_q << 3) + (acc_q << 1) + BITS'(cur_digit);
  end

`ifdef BCD_CHECK_EN
  always_comb begin
    invalid = 1'b0;
    for (int i = 0; i < int'(NUM_SEGMENTS); i++) begin
      if (digit_buf_q[i] > 4'd9) invalid = 1'b1;
    end
  end
`else
  assign invalid = 1'b0;
`endif

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q     <= StIdle;
      digit_buf_q <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      binary      <= '0;
      error       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            digit_buf_q <= encoded;
            acc_q       <= '0;
            idx_q       <= '0;
            busy        <= 1'b1;
            state_q     <= StConvert;
          end
        end
        StConvert: begin
          acc_q <= acc_next;
          idx_q <= idx_q + 1'b1;
          if (idx_q == IdxW'(NUM_SEGMENTS - 1)) state_q <= StDone;
        end
        StDone: begin
          binary  <= invalid ? '0 : acc_q;
          error   <= invalid;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: vector table plus restart, back-to-back and reset sequences.
module tb_bcd_to_bin;

  logic             clk = 1'b0;
  logic             CPU_RESETN = 1'b0;
  logic             start = 1'b0;
  logic [7:0][3:0]  encoded = '0;
  logic             busy, done, error;
  logic [31:0]      binary;
  logic             busy16, done16, error16;
  logic [15:0]      binary16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_to_bin #(.NUM_SEGMENTS(8), .BITS(32)) dut (
    .clk(clk), .CPU_RESETN(CPU_RESETN), .start(start), .encoded(encoded),
    .busy(busy), .done(done), .binary(binary), .error(error)
  );

  bcd_to_bin #(.NUM_SEGMENTS(8), .BITS(16)) dut16 (
    .clk(clk), .CPU_RESETN(CPU_RESETN), .start(start), .encoded(encoded),
    .busy(busy16), .done(done16), .binary(binary16), .error(error16)
  );

  typedef struct {
    logic [31:0] enc;
    logic [31:0] exp_bin;
    logic [15:0] exp_bin16;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Called #1 after a clock edge; returns #1 after the edge where done is seen (or timeout).
  task automatic convert(input logic [31:0] enc, output int lat);
    encoded = enc;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int first;

    vecs[0] = '{32'h1234_5678, 32'h00BC_614E, 16'h614E, 1'b0};
    vecs[1] = '{32'h9999_9999, 32'h05F5_E0FF, 16'hE0FF, 1'b0};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 16'h0000, 1'b0};
    vecs[3] = '{32'h0009_9999, 32'h0001_869F, 16'h869F, 1'b0};
`ifdef BCD_CHECK_EN
    vecs[4] = '{32'h000A_0001, 32'h0000_0000, 16'h0000, 1'b1};
`else
    vecs[4] = '{32'h000A_0001, 32'h0001_86A1, 16'h86A1, 1'b0};
`endif
    vecs[5] = '{32'h0000_0042, 32'h0000_002A, 16'h002A, 1'b0};
    vecs[6] = '{32'h1000_0000, 32'h0098_9680, 16'h9680, 1'b0};
    vecs[7] = '{32'h0000_0001, 32'h0000_0001, 16'h0001, 1'b0};

    // Reset state
    #12;
    check("reset_busy",   {31'd0, busy},  32'd0);
    check("reset_done",   {31'd0, done},  32'd0);
    check("reset_binary", binary,         32'd0);
    check("reset_error",  {31'd0, error}, 32'd0);
    @(posedge clk); #1;
    CPU_RESETN = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].enc, lat);
      check($sformatf("v%0d_latency", i), lat, 32'd9);
      check($sformatf("v%0d_binary", i), binary, vecs[i].exp_bin);
      check($sformatf("v%0d_error", i), {31'd0, error}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_binary16", i), {16'd0, binary16}, {16'd0, vecs[i].exp_bin16});
      @(posedge clk); #1;
      check($sformatf("v%0d_done_width", i), {31'd0, done}, 32'd0);
      check($sformatf("v%0d_hold", i), binary, vecs[i].exp_bin);
    end
    check("wrap16", {16'd0, binary16}, 32'h0000_0001);

    // Restart attempt 3 cycles in, with encoded changed: ignored
    encoded = 32'h1234_5678;
    start   = 1'b1;
    @(posedge clk); #1;
    ndone = 0;
    first = 0;
    for (int i = 1; i <= 24; i++) begin
      start = (i == 4);
      if (i == 4) encoded = 32'h9999_9999;
      @(posedge clk); #1;
      if (i == 5) check("restart_busy", {31'd0, busy}, 32'd1);
      if (i == 9) check("restart_busy_drop", {31'd0, busy}, 32'd0);
      if (done) begin
        ndone++;
        if (first == 0) first = i;
      end
    end
    start = 1'b0;
    check("restart_ndone",  ndone,  32'd1);
    check("restart_first",  first,  32'd9);
    check("restart_binary", binary, 32'h00BC_614E);

    // Back-to-back: start in the cycle right after done
    convert(32'h0000_0001, lat);
    check("b2b_first_lat", lat,    32'd9);
    check("b2b_first_bin", binary, 32'd1);
    convert(32'h0000_0099, lat);
    check("b2b_second_lat", lat,    32'd9);
    check("b2b_second_bin", binary, 32'h0000_0063);
    @(posedge clk); #1;

    // Reset at cycle 4 of a conversion
    encoded = 32'h1234_5678;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    CPU_RESETN = 1'b0;
    #1;
    check("rst_busy",   {31'd0, busy},  32'd0);
    check("rst_done",   {31'd0, done},  32'd0);
    check("rst_binary", binary,         32'd0);
    check("rst_error",  {31'd0, error}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) CPU_RESETN = 1'b1;
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("rst_no_done", ndone, 32'd0);
    convert(32'h0000_0042, lat);
    check("post_rst_lat", lat,    32'd9);
    check("post_rst_bin", binary, 32'h0000_002A);
    check("post_rst_err", {31'd0, error}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have parameter NUM_SEGMENTS, default 8, giving the number of BCD digits input (1..8).
REQ-002 SHALL have parameter BITS, default 32, giving the binary result width (4..32).
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port CPU_RESETN, input, 1, the reset, which is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle conversion request.
REQ-006 SHALL have port encoded, input, [NUM_SEGMENTS-1:0][3:0], the BCD digits; index NUM_SEGMENTS-1 is the most significant digit.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse marking a valid result.
REQ-009 SHALL have port binary, output, BITS, the converted value.
REQ-010 SHALL have port error, output, 1, flagging an invalid BCD digit in the last conversion.

Function
REQ-011 SHALL implement FSM states IDLE, CONVERT and DONE; IDLE is the reset state.
REQ-012 SHALL, in IDLE with start=1, register encoded into an internal digit buffer, clear the accumulator and digit index, set busy=1, and enter CONVERT.
REQ-013 SHALL, in CONVERT, process one digit per clock, MSD first: acc <= acc*10 + digit.
REQ-014 SHALL perform the accumulation at BITS width and keep the result modulo 2^BITS (overflow wraps, no flag).
REQ-015 SHALL leave CONVERT for DONE after exactly NUM_SEGMENTS cycles.
REQ-016 SHALL, in DONE, load binary from acc, pulse done=1 for one cycle, drop busy, and return to IDLE.
REQ-017 SHALL assert done on the NUM_SEGMENTS+1th rising edge after the edge that sampled start (9 cycles at default).
REQ-018 SHALL hold binary and error stable from done until the next DONE.
REQ-019 SHALL ignore start while in CONVERT or DONE, with no queuing and no restart.
REQ-020 SHALL accept a start that arrives in the cycle after done (back-to-back operation).
REQ-021 SHALL keep binary and error independent of encoded changes after the start edge, since conversion uses the captured copy.

Reset
REQ-022 SHALL, when CPU_RESETN=0, asynchronously force state=IDLE, busy=0, done=0, binary=0, error=0, acc=0 and index=0.
REQ-023 SHALL, on reset mid-conversion, abort the conversion with no done pulse; the next start after release converts normally.
REQ-024 SHALL release reset synchronously to clk (deassertion sampled on the clk edge).

Configuration
REQ-025 SHALL define the compile-time macro BCD_CHECK_EN to enable digit validity checking.
REQ-026 SHALL, with BCD_CHECK_EN defined, treat any captured digit >9 as invalid: at DONE, error=1 and binary=0; otherwise error=0.
REQ-027 SHALL, without BCD_CHECK_EN, tie error to 0 and accumulate raw nibble values (e.g. nibble 0xA adds 10) using the REQ-013 arithmetic.

Verification
REQ-028 SHALL verify: encoded=12345678, start pulse -> done 9 cycles later, binary=0x00BC614E, error=0.
REQ-029 SHALL verify: encoded=99999999 -> binary=0x05F5E0FF; encoded=00000000 -> binary=0x0; BITS=16 with 00099999 -> binary=0x869F (wrapped).
REQ-030 SHALL verify: BCD_CHECK_EN defined, encoded=000A0001 -> error=1, binary=0; BCD_CHECK_EN undefined, same input -> error=0, binary=0x000186A1 (100001).
REQ-031 SHALL verify: start pulsed again 3 cycles into a conversion and encoded changed -> single done, result reflects the original input; start in the cycle after done -> second done 9 cycles later.
REQ-032 SHALL verify: CPU_RESETN low at cycle 4 of a conversion -> busy/done/binary/error 0 immediately with no done pulse; after release, new start of 00000042 -> binary=0x2A.
